// File: rtl/m62_dl_pkg.sv
// rtl/m62_dl_pkg.sv - shared types and default bases for the ROM download sequencer
package m62_dl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        FLUSH
    } dl_state_t;

    typedef enum logic [1:0] {
        P1,
        P12,
        PROM
    } dl_region_t;

    localparam logic [24:0] DEF_SP_BASE    = 25'h30000;
    localparam logic [24:0] DEF_PROM_BASE  = 25'hA0000;
    localparam logic [15:0] DEF_RST_CYCLES = 16'hFFFF;

    function automatic dl_region_t decode_region(input logic [24:0] addr,
                                                 input logic [24:0] sp_base,
                                                 input logic [24:0] prom_base);
        if (addr < sp_base)
            return P1;
        else if (addr < prom_base)
            return P12;
        else
            return PROM;
    endfunction

endpackage

// File: rtl/m62_reset_gen.sv
// rtl/m62_reset_gen.sv - core reset hold counter, reloaded by any reset cause
module m62_reset_gen
    import m62_dl_pkg::*;
#(
    parameter logic [15:0] RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic reload,
    output logic core_reset
);

    logic [15:0] count;
    logic [15:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (reload)
            count_nxt = RST_CYCLES;
        else if (count != 16'd0)
            count_nxt = count - 16'd1;
    end

    // core_reset tracks the next count so it drops in the same cycle count reaches zero
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            count      <= RST_CYCLES;
            core_reset <= 1'b1;
        end else begin
            count      <= count_nxt;
            core_reset <= (count_nxt != 16'd0);
        end
    end

endmodule

// File: rtl/rom_dl_sequencer.sv
// rtl/rom_dl_sequencer.sv - routes ioctl download bytes to SDRAM ports or PROM; ROM_DL_PROM_EN enables PROM routing
module rom_dl_sequencer
    import m62_dl_pkg::*;
#(
    parameter logic [24:0] SP_BASE    = DEF_SP_BASE,
    parameter logic [24:0] PROM_BASE  = DEF_PROM_BASE,
    parameter logic [15:0] RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        reset_req,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port_ds,
    output logic [15:0] port_d,
    output logic        port_we,
    output logic        prom_wr,
    output logic [11:0] prom_addr,
    output logic [7:0]  prom_d,
    output logic        busy,
    output logic        overrun,
    output logic        rom_loaded,
    output logic        core_reset
);

    dl_state_t  state;
    dl_region_t region;
    logic       wr_prev;
    logic       downl_prev;
    logic       iss1;
    logic       iss2;
    logic       wr_edge;
    logic       downl_fall;
    logic       downl_rise;
    logic       acks_done;

    assign wr_edge    = ioctl_wr & ~wr_prev & ioctl_downl;
    assign downl_fall = downl_prev & ~ioctl_downl;
    assign downl_rise = ~downl_prev & ioctl_downl;
    // ports not touched by the current write never hold up completion
    assign acks_done  = (!iss1 || (port1_ack == port1_req)) &&
                        (!iss2 || (port2_ack == port2_req));
    assign busy       = (state != IDLE);

`ifdef ROM_DL_PROM_EN
    logic        prom_wr_q;
    logic [11:0] prom_addr_q;
    logic [7:0]  prom_d_q;

    assign region    = decode_region(ioctl_addr, SP_BASE, PROM_BASE);
    assign prom_wr   = prom_wr_q;
    assign prom_addr = prom_addr_q;
    assign prom_d    = prom_d_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            prom_wr_q   <= 1'b0;
            prom_addr_q <= '0;
            prom_d_q    <= '0;
        end else begin
            prom_wr_q <= 1'b0;
            if (wr_edge && state == IDLE) begin
                prom_addr_q <= 12'(ioctl_addr - PROM_BASE);
                prom_d_q    <= ioctl_dout;
                prom_wr_q   <= (region == PROM);
            end
        end
    end
`else
    dl_region_t region_raw;

    // without PROM routing the top region falls back to the primary port
    assign region_raw = decode_region(ioctl_addr, SP_BASE, PROM_BASE);
    assign region     = (region_raw == PROM) ? P1 : region_raw;
    assign prom_wr    = 1'b0;
    assign prom_addr  = '0;
    assign prom_d     = '0;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_prev    <= 1'b0;
            downl_prev <= 1'b0;
            iss1       <= 1'b0;
            iss2       <= 1'b0;
            port1_req  <= 1'b0;
            port2_req  <= 1'b0;
            port1_a    <= '0;
            port2_a    <= '0;
            port_ds    <= '0;
            port_d     <= '0;
            port_we    <= 1'b0;
            overrun    <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            wr_prev    <= ioctl_wr;
            downl_prev <= ioctl_downl;
            port_we    <= ioctl_downl;
            if (downl_rise)
                overrun <= 1'b0;
            if (wr_edge && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (wr_edge) begin
                        port1_a <= ioctl_addr[23:1];
                        port2_a <= 23'((ioctl_addr - SP_BASE) >> 1);
                        port_ds <= {ioctl_addr[0], ~ioctl_addr[0]};
                        port_d  <= {ioctl_dout, ioctl_dout};
                        case (region)
                            P1: begin
                                port1_req <= ~port1_req;
                                iss1      <= 1'b1;
                                iss2      <= 1'b0;
                                state     <= WAIT_ACK;
                            end
                            P12: begin
                                port1_req <= ~port1_req;
                                port2_req <= ~port2_req;
                                iss1      <= 1'b1;
                                iss2      <= 1'b1;
                                state     <= WAIT_ACK;
                            end
                            default: ;
                        endcase
                    end
                    if (downl_fall)
                        rom_loaded <= 1'b1;
                end
                WAIT_ACK: begin
                    if (acks_done) begin
                        state <= IDLE;
                        if (downl_fall)
                            rom_loaded <= 1'b1;
                    end else if (downl_fall) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (acks_done) begin
                        state      <= IDLE;
                        rom_loaded <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    m62_reset_gen #(
        .RST_CYCLES (RST_CYCLES)
    ) u_reset_gen (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .reload     (reset_req | ~rom_loaded | ioctl_downl),
        .core_reset (core_reset)
    );

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb/tb_rom_dl_sequencer.sv - randomized self-checking bench for rom_dl_sequencer
module tb_rom_dl_sequencer;

    localparam logic [24:0] SP   = 25'h30000;
    localparam logic [24:0] PRB  = 25'hA0000;
`ifdef ROM_DL_PROM_EN
    localparam bit PROM_EN = 1'b1;
`else
    localparam bit PROM_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_downl = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        reset_req = 1'b0;
    logic        port1_req, port2_req;
    logic        port1_ack = 1'b0;
    logic        port2_ack = 1'b0;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;
    logic        port_we, prom_wr, busy, overrun, rom_loaded, core_reset;
    logic [11:0] prom_addr;
    logic [7:0]  prom_d;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        e_r1 = 0, e_r2 = 0, e_ovr = 0;
    logic [22:0] e_p1a = 0, e_p2a = 0;
    logic [1:0]  e_ds = 0;
    logic [15:0] e_d = 0;
    logic [11:0] e_pa = 0;
    logic [7:0]  e_pd = 0;
    bit          m_busy = 0, m_iss1 = 0, m_iss2 = 0;

    rom_dl_sequencer dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .reset_req   (reset_req),
        .port1_req   (port1_req),
        .port1_ack   (port1_ack),
        .port1_a     (port1_a),
        .port2_req   (port2_req),
        .port2_ack   (port2_ack),
        .port2_a     (port2_a),
        .port_ds     (port_ds),
        .port_d      (port_d),
        .port_we     (port_we),
        .prom_wr     (prom_wr),
        .prom_addr   (prom_addr),
        .prom_d      (prom_d),
        .busy        (busy),
        .overrun     (overrun),
        .rom_loaded  (rom_loaded),
        .core_reset  (core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int region_of(input logic [24:0] a);
        if (a < SP) return 0;
        if (a < PRB) return 1;
        return PROM_EN ? 2 : 0;
    endfunction

    task automatic write_edge(input logic [24:0] a, input logic [7:0] d);
        logic [24:0] off;
        bit pulse;
        int r;
        pulse = 0;
        r = region_of(a);
        if (!m_busy) begin
            e_p1a = a[23:1];
            off   = a - SP;
            e_p2a = off[23:1];
            e_ds  = {a[0], ~a[0]};
            e_d   = {d, d};
            if (PROM_EN) begin
                off  = a - PRB;
                e_pa = off[11:0];
                e_pd = d;
            end
            case (r)
                0: begin e_r1 = ~e_r1; m_iss1 = 1; m_iss2 = 0; m_busy = 1; end
                1: begin e_r1 = ~e_r1; e_r2 = ~e_r2; m_iss1 = 1; m_iss2 = 1; m_busy = 1; end
                default: pulse = 1;
            endcase
        end else begin
            e_ovr = 1;
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        check("req1", port1_req, e_r1);
        check("req2", port2_req, e_r2);
        check("port1_a", port1_a, e_p1a);
        check("port2_a", port2_a, e_p2a);
        check("port_ds", port_ds, e_ds);
        check("port_d", port_d, e_d);
        check("prom_addr", prom_addr, e_pa);
        check("prom_d", prom_d, e_pd);
        check("busy_edge", busy, m_busy);
        check("overrun", overrun, e_ovr);
        check("prom_wr", prom_wr, pulse);
        if (pulse) begin
            tick();
            check("prom_wr_off", prom_wr, 0);
        end
    endtask

    task automatic finish_acks(input int d1, input int d2);
        if (m_busy) begin
            repeat (d1) tick();
            check("busy_hold", busy, 1);
            port1_ack = e_r1;
            tick();
            if (m_iss2) begin
                check("busy_p2", busy, 1);
                repeat (d2 - 1) tick();
                check("busy_p2_last", busy, 1);
                port2_ack = e_r2;
                tick();
            end
            check("busy_done", busy, 0);
            m_busy = 0; m_iss1 = 0; m_iss2 = 0;
        end else begin
            tick();
        end
    endtask

    initial begin
        int n;
        logic [24:0] a;
        repeat (2) tick();
        check("rst_req1", port1_req, 0);
        check("rst_req2", port2_req, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_loaded", rom_loaded, 0);
        check("rst_core", core_reset, 1);
        check("rst_prom_wr", prom_wr, 0);
        check("rst_p1a", port1_a, 0);
        reset_n = 1'b1;
        ioctl_downl = 1'b1;
        tick();
        check("port_we", port_we, 1);

        write_edge(25'h00010, 8'h5A);
        check("dir_p1a", port1_a, 23'h8);
        check("dir_ds", port_ds, 2'b01);
        check("dir_d", port_d, 16'h5A5A);
        finish_acks(3, 1);

        write_edge(25'h30003, 8'hC3);
        check("dir_p2a", port2_a, 23'h1);
        check("dir_ds2", port_ds, 2'b10);
        finish_acks(2, 5);

        write_edge(25'hA0105, 8'h3C);
        if (PROM_EN) check("dir_prom_a", prom_addr, 12'h105);
        finish_acks(1, 1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: a = 25'($urandom_range(0, 32'h2FFFF));
                1: a = 25'($urandom_range(32'h30000, 32'h9FFFF));
                default: a = 25'($urandom_range(32'hA0000, 32'h1FFFFFF));
            endcase
            write_edge(a, 8'($urandom));
            finish_acks($urandom_range(0, 4), $urandom_range(1, 6));
        end

        write_edge(25'h00100, 8'h11);
        tick();
        write_edge(25'h00200, 8'h22);
        finish_acks(1, 1);

        write_edge(25'h00040, 8'h44);
        ioctl_downl = 1'b0;
        tick();
        check("flush_busy", busy, 1);
        check("flush_loaded", rom_loaded, 0);
        tick();
        check("flush_loaded2", rom_loaded, 0);
        port1_ack = e_r1;
        m_busy = 0; m_iss1 = 0; m_iss2 = 0;
        tick();
        check("flush_done", busy, 0);
        check("loaded", rom_loaded, 1);
        n = 0;
        while (core_reset && n < 70000) begin
            tick();
            n++;
        end
        check("core_rst_len", n, 65535);
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
        check("core_rst_reload", core_reset, 1);

        ioctl_downl = 1'b1;
        tick();
        e_ovr = 0;
        check("ovr_clear", overrun, 0);
        check("loaded_kept", rom_loaded, 1);
        tick();

        write_edge(25'h00050, 8'h55);
        reset_n = 1'b0;
        port1_ack = 1'b0;
        port2_ack = 1'b0;
        tick();
        check("mid_req1", port1_req, 0);
        check("mid_req2", port2_req, 0);
        check("mid_busy", busy, 0);
        check("mid_ovr", overrun, 0);
        check("mid_loaded", rom_loaded, 0);
        check("mid_core", core_reset, 1);
        check("mid_p1a", port1_a, 0);
        check("mid_d", port_d, 0);
        check("mid_prom_wr", prom_wr, 0);
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_dl_sequencer.md
ROM_DL_SEQUENCER -- requirements
Module: rom_dl_sequencer

Interface
REQ-001 Parameter SP_BASE, 25'h30000, first byte address of the sprite-graphics region; the region is also mirrored to port2.
REQ-002 Parameter PROM_BASE, 25'hA0000, first byte address of the colour/height PROM region.
REQ-003 Parameter RST_CYCLES, 16'hFFFF, core-reset hold count after the last reset cause.
REQ-004 The ports SHALL be as follows; clock and reset come first:
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_downl  in  1  download in progress.
- ioctl_wr  in  1  byte-write strobe, level.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- reset_req  in  1  user reset request, active-high.
- port1_req / port2_req  out  1  toggle requests to the SDRAM ports.
- port1_ack / port2_ack  in  1  toggle acknowledges from the SDRAM ports.
- port1_a / port2_a  out  23  word addresses; port2_a is taken from ioctl_addr-SP_BASE.
- port_ds  out  2  byte strobes {a[0],~a[0]}.
- port_d  out  16  {byte,byte}.
- port_we  out  1  equals ioctl_downl, registered.
- prom_wr  out  1  one-cycle PROM write pulse.
- prom_addr  out  12  ioctl_addr-PROM_BASE.
- prom_d  out  8  PROM data.
- busy  out  1  a write is outstanding (state != IDLE).
- overrun  out  1  sticky: a write edge arrived while busy.
- rom_loaded  out  1  sticky: a download completed.
- core_reset  out  1  active-high reset to the game core.

Function
REQ-005 A write edge SHALL be ioctl_wr=1 while its registered previous value=0, qualified by ioctl_downl=1.
REQ-006 The FSM SHALL have the states IDLE, WAIT_ACK and FLUSH.
REQ-007 IDLE with a write edge:
- Latch address and data.
- Decode the region:
  - addr<SP_BASE: P1.
  - SP_BASE<=addr<PROM_BASE: P1+P2.
  - addr>=PROM_BASE: PROM.
- Toggle the selected reqs on the same clock edge; they are visible the next cycle.
- Go to WAIT_ACK.
REQ-008 In WAIT_ACK, the FSM SHALL return to IDLE on the first cycle in which every issued port has ack==req.
- An unissued port is ignored.
- No timeout.
REQ-009 A PROM-region write SHALL pulse prom_wr for exactly one cycle, the cycle after the edge.
- It SHALL leave the port reqs untouched.
- It SHALL stay in IDLE.
REQ-010 A write edge while state!=IDLE SHALL set overrun and SHALL be dropped; no req toggles.
REQ-011 When ioctl_downl falls, the FSM SHALL go to FLUSH if the state is WAIT_ACK, otherwise it SHALL set rom_loaded next cycle.
- FLUSH completes the outstanding ack, then sets rom_loaded and goes to IDLE.
REQ-012 A new ioctl_downl rise SHALL clear overrun and SHALL NOT clear rom_loaded.
REQ-013 Held outputs (port*_a, port_ds, port_d, prom_addr, prom_d) SHALL stay stable from latch until the next accepted write.
REQ-014 Address subtraction SHALL be 25-bit with modulo wrap; only the stated low bits are output.
REQ-015 Reset counter:
- Reloaded to RST_CYCLES while reset_req=1, rom_loaded=0 or ioctl_downl=1.
- Otherwise it decrements to 0 and holds.
- core_reset = (count!=0), registered.

Reset
REQ-016 On reset_n=0 at a clk_sys edge:
- State IDLE.
- port1_req=port2_req=0.
- prom_wr=0, busy=0, overrun=0, rom_loaded=0.
- core_reset=1.
- Counter = RST_CYCLES.
- Held data registers = 0.
REQ-017 A reset during WAIT_ACK SHALL abandon the write; the SDRAM controller must also be reset so that ack returns to 0.

Configuration
REQ-018 Macro ROM_DL_PROM_EN:
- Defined: the PROM routing of REQ-009 applies.
- Undefined: addr>=PROM_BASE is treated as P1 only, prom_wr is tied 0, and prom_addr/prom_d are tied 0.

Structure
REQ-019 Package m62_dl_pkg SHALL hold:
- the state enum (IDLE, WAIT_ACK, FLUSH);
- the region enum (P1, P12, PROM);
- default base constants.
REQ-020 The reset counter of REQ-015 SHALL be the sub-module m62_reset_gen; the FSM and datapath stay in rom_dl_sequencer.

Verification
REQ-021 A bench SHALL cover these scenarios:
- Write addr 25'h00010, data 8'h5A:
  - port1_req toggles 1 cycle after the edge, port1_a=23'h8, port_ds=2'b01, port_d=16'h5A5A;
  - busy stays 1 until ack is echoed 3 cycles later.
- Write addr 25'h30003:
  - both reqs toggle, port2_a=23'h1, port_ds=2'b10;
  - IDLE only after port2_ack is returned 5 cycles after port1_ack.
- Write addr 25'hA0105, data 8'h3C, macro defined: prom_wr pulses once with prom_addr=12'h105, no req toggles; with the macro undefined, port1_req toggles instead.
- Second write edge while awaiting ack: overrun=1, req toggled once only; the next download start clears overrun.
- ioctl_downl falls during WAIT_ACK: rom_loaded rises only after the ack; core_reset deasserts 65535 cycles later; reset_req=1 reloads it.
- reset_n=0 mid-WAIT_ACK: all outputs at reset values the next cycle, core_reset=1.
